// File: rtl/psum_pkg.sv
// rtl/psum_pkg.sv - shared constants for the nibble-serial partial-sum accumulator
// Holds the FSM state encoding, the slice width and the signed-overflow rule.
package psum_pkg;

  localparam int NIB_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Overflow when both addends share a sign and the result does not.
  function automatic logic signed_ovf(input logic op_msb, input logic acc_msb,
                                      input logic sum_msb);
    return (op_msb == acc_msb) && (sum_msb != op_msb);
  endfunction

endpackage

// File: rtl/psum_nibble_accumulator_add4_slice.sv
// rtl/psum_nibble_accumulator_add4_slice.sv - 4-bit add slice used once per ADD cycle
// Purely combinational: sum = a + b + cin, cout is the fifth bit.
module add4_slice
  import psum_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};
  assign sum  = full[NIB_W-1:0];
  assign cout = full[NIB_W];

endmodule

// File: rtl/psum_nibble_accumulator.sv
// rtl/psum_nibble_accumulator.sv - nibble-serial signed accumulator with sticky overflow
// Optional macro PSUM_SAT_EN: saturate acc on overflow instead of wrapping.
module psum_nibble_accumulator
  import psum_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int NIB   = ACC_W / NIB_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf
);

  localparam int IDX_W = $clog2(NIB);

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] op_q, op_d;
  logic             last_q, last_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [IDX_W-1:0] nib_q, nib_d;

  logic [NIB_W-1:0] sl_a, sl_b, sl_sum;
  logic             sl_cout;
  logic             ovf_now;

  assign sl_a = acc_q[int'(nib_q) * NIB_W +: NIB_W];
  assign sl_b = op_q[int'(nib_q) * NIB_W +: NIB_W];

  add4_slice u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  // Only meaningful on the top-nibble cycle, where sl_sum carries the new MSB.
  assign ovf_now = signed_ovf(op_q[ACC_W-1], acc_q[ACC_W-1], sl_sum[NIB_W-1]);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    last_d  = last_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    nib_d   = nib_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = in_data;
          last_d  = in_last;
          nib_d   = '0;
          carry_d = 1'b0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        acc_d[int'(nib_q) * NIB_W +: NIB_W] = sl_sum;
        carry_d = sl_cout;
        nib_d   = nib_q + 1'b1;
        if (nib_q == IDX_W'(NIB - 1)) begin
          nib_d   = '0;
          carry_d = 1'b0;
          if (ovf_now) begin
            ovf_d = 1'b1;
`ifdef PSUM_SAT_EN
            acc_d = op_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                  : {1'b0, {(ACC_W-1){1'b1}}};
`endif
          end
          state_d = last_q ? ST_HOLD : ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      op_q    <= '0;
      last_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      nib_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      last_q  <= last_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      nib_q   <= nib_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_HOLD) && !rst;
  assign out_data  = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_psum_nibble_accumulator.sv
// tb/tb_psum_nibble_accumulator.sv - self-checking bench for psum_nibble_accumulator
// Directed table, reset/backpressure sequences, then random groups against an integer model.
module tb_psum_nibble_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_ovf;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  psum_nibble_accumulator #(.ACC_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Entry and exit are always 1 time unit after a rising edge.
  task automatic push(input logic [15:0] d, input logic l, output int hs_cyc);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!in_ready) chk("push_ready_timeout", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clk);
    hs_cyc = cyc;
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) chk("out_valid_timeout", {31'b0, out_valid}, 32'd1);
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_sum;
    logic        exp_ovf;
  } vec_t;

  vec_t vt[5];

  initial begin
    int h0, h1, lat, macc, s, n;
    logic movf;
    logic [15:0] op;

    vt[0] = '{16'h0003, 16'h0005, 16'h0008, 1'b0};
    vt[1] = '{16'h0FFF, 16'h0001, 16'h1000, 1'b0};
    vt[2] = '{16'hFFFF, 16'hFFFE, 16'hFFFD, 1'b0};
`ifdef PSUM_SAT_EN
    vt[3] = '{16'h7FFF, 16'h0001, 16'h7FFF, 1'b1};
    vt[4] = '{16'h8000, 16'hFFFF, 16'h8000, 1'b1};
`else
    vt[3] = '{16'h7FFF, 16'h0001, 16'h8000, 1'b1};
    vt[4] = '{16'h8000, 16'hFFFF, 16'h7FFF, 1'b1};
`endif

    // Reset held for two edges, outputs quiet throughout.
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("post_rst_out_ovf", {31'b0, out_ovf}, 32'd0);
    chk("post_rst_out_data", {16'b0, out_data}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      push(vt[i].a, 1'b0, h0);
      push(vt[i].b, 1'b1, h1);
      chk("throughput", h1 - h0, 32'd5);
      wait_out(lat);
      chk("latency", lat, 32'd4);
      chk("tbl_sum", {16'b0, out_data}, {16'b0, vt[i].exp_sum});
      chk("tbl_ovf", {31'b0, out_ovf}, {31'b0, vt[i].exp_ovf});
      pop();
      chk("tbl_clr_data", {16'b0, out_data}, 32'd0);
      chk("tbl_clr_ovf", {31'b0, out_ovf}, 32'd0);
      chk("tbl_in_ready", {31'b0, in_ready}, 32'd1);
    end

    // Backpressure: result must hold while in_valid is asserted and ignored.
    push(16'h1111, 1'b0, h0);
    push(16'h2222, 1'b1, h1);
    wait_out(lat);
    in_valid = 1'b1;
    in_data  = 16'h0F0F;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_data", {16'b0, out_data}, 32'h3333);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    pop();
    chk("bp_after_in_ready", {31'b0, in_ready}, 32'd1);
    chk("bp_after_valid", {31'b0, out_valid}, 32'd0);

    // Reset during the second ADD cycle abandons the group.
    push(16'h1234, 1'b1, h0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_data", {16'b0, out_data}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    push(16'h0001, 1'b1, h0);
    wait_out(lat);
    chk("midrst_latency", lat, 32'd4);
    chk("midrst_sum", {16'b0, out_data}, 32'h0001);
    chk("midrst_ovf", {31'b0, out_ovf}, 32'd0);
    pop();

    // Random groups against a plain signed-integer model.
    for (int g = 0; g < 60; g++) begin
      n    = $urandom_range(1, 5);
      macc = 0;
      movf = 1'b0;
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 5))
          0:       op = 16'h7FFF;
          1:       op = 16'h8000;
          default: op = 16'($urandom);
        endcase
        s = macc + int'($signed(op));
        if (s > 32767 || s < -32768) begin
          movf = 1'b1;
`ifdef PSUM_SAT_EN
          macc = op[15] ? -32768 : 32767;
`else
          macc = int'($signed(s[15:0]));
`endif
        end else begin
          macc = s;
        end
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        push(op, k == n - 1, h0);
      end
      wait_out(lat);
      chk("rnd_latency", lat, 32'd4);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      chk("rnd_sum", {16'b0, out_data}, {16'b0, macc[15:0]});
      chk("rnd_ovf", {31'b0, out_ovf}, {31'b0, movf});
      pop();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/psum_nibble_accumulator.md
PSUM_NIBBLE_ACCUMULATOR -- requirements
Module: psum_nibble_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 16, accumulator and operand width in bits; it SHALL be a multiple of 4 and at least 8.
REQ-002 SHALL have parameter NIB, default ACC_W/4, the number of nibble slices per add; it is derived and not overridden.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: an operand is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts an operand this cycle.
REQ-007 SHALL have port in_data, input, ACC_W bits: two's-complement partial product.
REQ-008 SHALL have port in_last, input, 1 bit: this is the final operand of the current output group.
REQ-009 SHALL have port out_valid, output, 1 bit: the accumulated result is presented.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 SHALL have port out_data, output, ACC_W bits: the accumulated sum.
REQ-012 SHALL have port out_ovf, output, 1 bit: sticky signed overflow for the group.

Function
REQ-013 SHALL implement states IDLE, ADD and HOLD.
REQ-014 SHALL drive in_ready=1 only in IDLE; an input handshake is in_valid and in_ready both 1.
REQ-015 On an input handshake, SHALL latch in_data and in_last, clear the nibble index and the carry flop, and enter ADD.
REQ-016 In ADD, SHALL add one 4-bit nibble per cycle, LSB nibble first: acc[4i+3:4i] plus op[4i+3:4i] plus carry; the nibble carry-out is registered for the next cycle.
REQ-017 ADD SHALL last exactly NIB cycles; carry-out of the top nibble SHALL be discarded.
REQ-018 At the end of the last nibble cycle, signed overflow SHALL be computed as operand MSB equal to old acc MSB and different from new acc MSB; out_ovf SHALL be set sticky.
REQ-019 After ADD, SHALL enter HOLD if the latched last flag is 1, else IDLE.
REQ-020 In HOLD, SHALL assert out_valid and keep out_data and out_ovf stable until out_ready=1.
REQ-021 On an output handshake, SHALL clear acc and out_ovf to 0 and enter IDLE, with in_ready=1 on the next cycle.
REQ-022 in_valid is ignored outside IDLE; out_ready is ignored outside HOLD.
REQ-023 Throughput SHALL be one operand per NIB+1 cycles; result latency SHALL be NIB cycles from the last handshake to out_valid=1.
REQ-024 out_data SHALL equal acc at all times; it is meaningful only while out_valid=1.

Reset
REQ-025 rst=1 SHALL asynchronously force state IDLE, acc=0, carry=0, nibble index=0, out_ovf=0, out_valid=0 and in_ready=0 while asserted.
REQ-026 After rst deasserts, in_ready SHALL be 1 from the first clock edge.
REQ-027 Reset during ADD or HOLD SHALL abandon the group with no partial output.

Configuration
REQ-028 With macro PSUM_SAT_EN defined, an add that overflows SHALL replace acc with the saturated value: 0x7F..F if the operand MSB is 0, 0x80..0 if it is 1. Later adds continue from that value.
REQ-029 Without PSUM_SAT_EN, acc SHALL wrap modulo 2^ACC_W; out_ovf behaves identically in both builds.

Structure
REQ-030 State encoding and the nibble width constant 4 SHALL reside in shared package psum_pkg.
REQ-031 The per-cycle nibble add SHALL be instantiated as sub-module add4_slice: combinational a[3:0], b[3:0], cin → sum[3:0], cout. A carry-select slice is acceptable.

Verification (ACC_W=16)
REQ-032 Reset: assert rst for 2 cycles, then release → out_valid=0, out_ovf=0, in_ready=1 on the first edge.
REQ-033 Basic sum: send 0x0003, then 0x0005 with in_last → out_valid exactly 4 cycles after the second handshake, out_data=0x0008, out_ovf=0.
REQ-034 Carry ripple and negatives:
- 0x0FFF, then 0x0001 with last → 0x1000.
- 0xFFFF, then 0xFFFE with last → 0xFFFD, out_ovf=0.
REQ-035 Overflow: send 0x7FFF, then 0x0001 with last.
- Default build: out_data=0x8000, out_ovf=1.
- PSUM_SAT_EN build: out_data=0x7FFF, out_ovf=1.
- After the output handshake, the next group starts at 0 with out_ovf=0.
REQ-036 Backpressure: hold out_ready=0 for 3 cycles in HOLD → out_data stable, in_ready=0 and in_valid ignored; on out_ready=1 → handshake, then in_ready=1.
REQ-037 Reset mid-ADD: assert rst in the 2nd ADD cycle of 0x1234 → acc=0; then send 0x0001 with last → out_data=0x0001.
